// File: rtl/singleport_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : singleport_pkg                                                |
// | Purpose  : Shared constants, types and the operation decode for the     |
// |            16 x 8 single-port RAM.                                       |
// | Contents : DATA_W, ADDR_W, DEPTH, word_t, addr_t, op_e, decode_op()      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package singleport_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Encodings match the {we,en} pair directly so the decode is a pure relabel.
  typedef enum logic [1:0] {
    OP_IDLE     = 2'b00,
    OP_READ     = 2'b01,
    OP_WRITE    = 2'b10,
    OP_CONFLICT = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic we, input logic en);
    op_e op;
    case ({we, en})
      2'b10:   op = OP_WRITE;
      2'b01:   op = OP_READ;
      2'b11:   op = OP_CONFLICT;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/singleport_bus_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : singleport_bus_drv                                            |
// | Purpose  : Tri-state driver for the shared RAM data bus. Keeps the 'z'   |
// |            assignment separate from the storage array.                   |
// | Ports    : i_oe     - drive enable (1 = drive i_word, 0 = release bus)   |
// |            i_word   - word to place on the bus                           |
// |            io_data  - bidirectional data bus                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module singleport_bus_drv
  import singleport_pkg::*;
(
  input  logic              i_oe,
  input  word_t             i_word,
  inout  wire  [DATA_W-1:0] io_data
);

  assign io_data = i_oe ? i_word : 'z;

endmodule
`default_nettype wire

// File: rtl/singleport_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : singleport_ram                                                |
// | Purpose  : 16 x 8 single-port RAM on a bidirectional data bus.           |
// |            Synchronous write, combinational read by default.             |
// | Ports    : clk  - system clock (rising edge)                             |
// |            rst  - synchronous active-high reset, clears all words        |
// |            we   - write enable                                           |
// |            en   - read (output) enable                                   |
// |            data - bidirectional data bus                                 |
// |            addr - word address                                           |
// | Options  : SINGLEPORT_RDREG_EN - registered read path, 1-cycle latency   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module singleport_ram
  import singleport_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              en,
  inout  wire  [DATA_W-1:0] data,
  input  addr_t             addr
);

  word_t r_mem [DEPTH];

  op_e   w_op;
  logic  w_rd;
  logic  w_drv_en;
  word_t w_drv_word;

  assign w_op = decode_op(we, en);
  // Reset overrides everything: the bus must stay released while rst is high.
  assign w_rd = (w_op == OP_READ) && !rst;

  // Storage. Conflict and idle leave the array untouched; a write on a reset
  // edge is discarded because the clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[addr_t'(i)] <= '0;
      end
    end else if (w_op == OP_WRITE) begin
      r_mem[addr] <= data;
    end
  end

`ifdef SINGLEPORT_RDREG_EN
  word_t r_rdata_q;
  logic  r_rd_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_q <= '0;
      r_rd_prev <= 1'b0;
    end else begin
      r_rd_prev <= w_rd;
      if (w_rd) begin
        r_rdata_q <= r_mem[addr];
      end
    end
  end

  // Drive only once read mode has persisted across an edge, so the bus
  // carries a word captured while read mode was already active.
  assign w_drv_en   = w_rd && r_rd_prev;
  assign w_drv_word = r_rdata_q;
`else
  assign w_drv_en   = w_rd;
  assign w_drv_word = r_mem[addr];
`endif

  singleport_bus_drv u_bus_drv (
    .i_oe    (w_drv_en),
    .i_word  (w_drv_word),
    .io_data (data)
  );

endmodule
`default_nettype wire

// File: tb/tb_singleport_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_singleport_ram                                             |
// | Purpose  : Directed self-checking bench for singleport_ram.              |
// |            Whenever the RAM should release the bus, the bench parks its  |
// |            own driver on the bus and expects to read that value back.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_singleport_ram;

  logic       clk;
  logic       rst;
  logic       we;
  logic       en;
  logic [3:0] addr;
  logic       tb_oe;
  logic [7:0] tb_val;
  wire  [7:0] data;

  int n_checks;
  int n_errors;

  assign data = tb_oe ? tb_val : 'z;

  singleport_ram dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .en   (en),
    .data (data),
    .addr (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write is committed at the next rising edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic r);
    @(negedge clk);
    rst    = r;
    we     = 1'b1;
    en     = 1'b0;
    addr   = a;
    tb_oe  = 1'b1;
    tb_val = d;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    rst   = 1'b0;
    we    = 1'b0;
    en    = 1'b1;
    addr  = a;
    tb_oe = 1'b0;
`ifdef SINGLEPORT_RDREG_EN
    @(posedge clk);
`endif
    #1;
    chk(tag, data, exp);
  endtask

  // Idle cycle with the bench parking 8'h00 on the bus; addr should hold a
  // nonzero word so that any RAM drive would disturb the parked value.
  task automatic idle(input logic [3:0] a, input logic do_chk, input string tag);
    @(negedge clk);
    rst    = 1'b0;
    we     = 1'b0;
    en     = 1'b0;
    addr   = a;
    tb_oe  = 1'b1;
    tb_val = 8'h00;
    #1;
    if (do_chk) chk(tag, data, 8'h00);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst    = 1'b1;
    we     = 1'b0;
    en     = 1'b1;
    addr   = 4'd0;
    tb_oe  = 1'b1;
    tb_val = 8'h00;

    // Reset: bus released during rst, then every word reads 0.
    @(negedge clk);
    #1;
    chk("rst_bus_z", data, 8'h00);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "rst_clear");

    // Write sweep of 8'h06.
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h06, 1'b0);
    idle(4'd0, 1'b1, "idle_z_sweep");
    for (int i = 0; i < 16; i++) rd(4'(i), 8'h06, "sweep");

    // Pattern 8'h10+i, read back in reverse order.
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h10 + 8'(i), 1'b0);
    idle(4'd3, 1'b1, "idle_z_pat");
    for (int i = 15; i >= 0; i--) rd(4'(i), 8'h10 + 8'(i), "pattern");
    idle(4'd15, 1'b1, "idle_z_pat2");

    // Back-to-back writes to one address: last edge wins.
    wr(4'd9, 8'h77, 1'b0);
    wr(4'd9, 8'h99, 1'b0);
    rd(4'd9, 8'h99, "last_wins");

    // Conflict: master drives 8'h3C on addr 5, RAM must neither drive nor write.
    wr(4'd5, 8'hA5, 1'b0);
    @(negedge clk);
    we     = 1'b1;
    en     = 1'b1;
    addr   = 4'd5;
    tb_oe  = 1'b1;
    tb_val = 8'h3C;
    #1;
    chk("conflict_nodrv", data, 8'h3C);
    idle(4'd5, 1'b1, "idle_z_conf");
    rd(4'd5, 8'hA5, "conflict_nowr");

    // Read-path timing: combinational update on addr change mid-cycle.
`ifdef SINGLEPORT_RDREG_EN
    rd(4'd2, 8'h12, "rdreg_a2");
    rd(4'd3, 8'h13, "rdreg_a3");
`else
    @(negedge clk);
    we    = 1'b0;
    en    = 1'b1;
    addr  = 4'd2;
    tb_oe = 1'b0;
    #1;
    chk("comb_a2", data, 8'h12);
    #2;
    addr = 4'd3;
    #1;
    chk("comb_a3", data, 8'h13);
`endif

    // Read request while rst is high with nonzero contents: bus stays released.
    @(negedge clk);
    rst    = 1'b1;
    we     = 1'b0;
    en     = 1'b1;
    addr   = 4'd3;
    tb_oe  = 1'b1;
    tb_val = 8'h00;
    #1;
    chk("rst_rd_z", data, 8'h00);

    // Reset mid-burst: rst on the edge of the addr-4 write.
    for (int i = 0; i < 8; i++) wr(4'(i), 8'h30 + 8'(i), (i == 4));
    idle(4'd7, 1'b0, "");
    for (int i = 0; i < 5; i++) rd(4'(i), 8'h00, "burst_lost");
    for (int i = 5; i < 8; i++) rd(4'(i), 8'h30 + 8'(i), "burst_kept");
    rd(4'd12, 8'h00, "burst_cleared");

    idle(4'd0, 1'b0, "");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
